// File: rtl/ctrl_pkg.sv
// Shared types for the run sequencer: FSM state encoding and default counter width.
package ctrl_pkg;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      PAUSE,
      DONE
   } seq_state_t;
endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter that saturates at zero; is_one flags the last owed cycle.
module cycle_down_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             is_one
);

   // load wins over dec; dec at zero is a no-op so the count never wraps
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/run_sequencer.sv
// Sequences a datapath through one bounded run: one clr cycle, then en for len cycles,
// with pause/resume, abort and a one-cycle done pulse on normal completion.
module run_sequencer
   import ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [CNT_W-1:0] len,
   output logic             en,
   output logic             clr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   seq_state_t state, next_state;
   logic       load;
   logic       dec;
   logic       is_one;

   cycle_down_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .load_val (len),
      .dec      (dec),
      .count    (remaining),
      .is_one   (is_one)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Every RUN cycle is an enabled cycle, so it always decrements, even when aborting
   always_comb begin
      next_state = state;
      load       = 1'b0;
      dec        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = CLEAR;
               load       = 1'b1;
            end
         end
         CLEAR: begin
            if (stop) begin
               next_state = IDLE;
            end else if (remaining == '0) begin
               next_state = DONE;
            end else begin
               next_state = RUN;
            end
         end
         RUN: begin
            dec = 1'b1;
            if (stop) begin
               next_state = IDLE;
            end else if (is_one) begin
               next_state = DONE;
            end else if (pause) begin
               next_state = PAUSE;
            end
         end
         PAUSE: begin
            if (stop) begin
               next_state = IDLE;
            end else if (!pause) begin
               next_state = RUN;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign en   = (state == RUN);
   assign clr  = (state == CLEAR);
   assign done = (state == DONE);
   assign busy = (state == CLEAR) || (state == RUN) || (state == PAUSE) || (state == DONE);

endmodule

// File: tb/tb_run_sequencer.sv
// Cycle-by-cycle vector bench for run_sequencer plus hand-written async-reset sequence.
module tb_run_sequencer;

   localparam int CNT_W = 16;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             stop;
   logic             pause;
   logic [CNT_W-1:0] len;
   logic             en;
   logic             clr;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic             start;
      logic             stop;
      logic             pause;
      logic [CNT_W-1:0] len;
      logic             en;
      logic             clr;
      logic             busy;
      logic             done;
      logic [CNT_W-1:0] rem;
   } vec_t;

   vec_t vecs[$];
   logic [CNT_W+3:0] sb[$];

   run_sequencer #(
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .len       (len),
      .en        (en),
      .clr       (clr),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic void v(input logic st, input logic sp, input logic pa, input int ln,
                             input logic e_en, input logic e_clr, input logic e_busy,
                             input logic e_done, input int e_rem);
      vec_t r;
      r.start = st;  r.stop = sp;  r.pause = pa;  r.len = ln[CNT_W-1:0];
      r.en = e_en;   r.clr = e_clr; r.busy = e_busy; r.done = e_done;
      r.rem = e_rem[CNT_W-1:0];
      vecs.push_back(r);
   endfunction

   task automatic check(input string name, input logic [CNT_W+3:0] got, input logic [CNT_W+3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got={en,clr,busy,done,rem}=%h required=%h", name, got, exp);
      end
   endtask

   function automatic logic [CNT_W+3:0] outs();
      return {en, clr, busy, done, remaining};
   endfunction

   initial begin
      logic [CNT_W+3:0] exp_o;
      vec_t r;

      start = 0; stop = 0; pause = 0; len = '0; reset_n = 1'b0;
      #1;
      check("reset_async", outs(), '0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", outs(), '0);
      @(negedge clk);
      reset_n = 1'b1;

      // nominal len=5
      v(1,0,0,5, 0,1,1,0,5);
      v(0,0,0,0, 1,0,1,0,5);
      v(0,0,0,0, 1,0,1,0,4);
      v(0,0,0,0, 1,0,1,0,3);
      v(0,0,0,0, 1,0,1,0,2);
      v(0,0,0,0, 1,0,1,0,1);
      v(0,0,0,0, 0,0,1,1,0);
      v(0,0,0,0, 0,0,0,0,0);
      // zero length
      v(1,0,0,0, 0,1,1,0,0);
      v(0,0,0,0, 0,0,1,1,0);
      v(0,0,0,0, 0,0,0,0,0);
      // pause after 2nd en, held for 3 cycles
      v(1,0,0,6, 0,1,1,0,6);
      v(0,0,0,0, 1,0,1,0,6);
      v(0,0,0,0, 1,0,1,0,5);
      v(0,0,1,0, 0,0,1,0,4);
      v(0,0,1,0, 0,0,1,0,4);
      v(0,0,1,0, 0,0,1,0,4);
      v(0,0,0,0, 1,0,1,0,4);
      v(0,0,0,0, 1,0,1,0,3);
      v(0,0,0,0, 1,0,1,0,2);
      v(0,0,0,0, 1,0,1,0,1);
      v(0,0,0,0, 0,0,1,1,0);
      v(0,0,0,0, 0,0,0,0,0);
      // stop during 4th en cycle of len=10; remaining holds in IDLE
      v(1,0,0,10, 0,1,1,0,10);
      v(0,0,0,0,  1,0,1,0,10);
      v(0,0,0,0,  1,0,1,0,9);
      v(0,0,0,0,  1,0,1,0,8);
      v(0,0,0,0,  1,0,1,0,7);
      v(0,1,0,0,  0,0,0,0,6);
      v(0,0,0,0,  0,0,0,0,6);
      // stop during PAUSE
      v(1,0,0,4, 0,1,1,0,4);
      v(0,0,0,0, 1,0,1,0,4);
      v(0,0,1,0, 0,0,1,0,3);
      v(0,1,1,0, 0,0,0,0,3);
      v(0,0,0,0, 0,0,0,0,3);
      // stop during CLEAR
      v(1,0,0,3, 0,1,1,0,3);
      v(0,1,0,0, 0,0,0,0,3);
      // collision: busy start ignored, pause loses to completion, start held through DONE
      v(1,0,0,3, 0,1,1,0,3);
      v(0,0,0,0, 1,0,1,0,3);
      v(1,0,0,7, 1,0,1,0,2);
      v(0,0,0,0, 1,0,1,0,1);
      v(1,0,1,2, 0,0,1,1,0);
      v(1,0,0,2, 0,0,0,0,0);
      v(1,0,0,2, 0,1,1,0,2);
      v(0,0,0,0, 1,0,1,0,2);
      v(0,0,0,0, 1,0,1,0,1);
      v(0,0,0,0, 0,0,1,1,0);
      v(0,0,0,0, 0,0,0,0,0);
      // maximum length, then stop/pause ignored in IDLE
      v(1,0,0,65535, 0,1,1,0,65535);
      v(0,0,0,0,     1,0,1,0,65535);
      v(0,0,0,0,     1,0,1,0,65534);
      v(0,1,0,0,     0,0,0,0,65533);
      v(0,1,1,0,     0,0,0,0,65533);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         r = vecs[i];
         start = r.start; stop = r.stop; pause = r.pause; len = r.len;
         sb.push_back({r.en, r.clr, r.busy, r.done, r.rem});
         @(posedge clk);
         #1;
         exp_o = sb.pop_front();
         check($sformatf("vec%0d", i), outs(), exp_o);
      end

      // async reset asserted between edges in the middle of a run
      @(negedge clk);
      start = 1; stop = 0; pause = 0; len = 16'd8;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      check("pre_reset_run", outs(), {1'b1, 1'b0, 1'b1, 1'b0, 16'd7});
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_mid_run", outs(), '0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_reset_idle%0d", k), outs(), '0);
      end

      // single-cycle run after reset
      @(negedge clk);
      start = 1; len = 16'd1;
      @(posedge clk); #1;
      check("len1_clear", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 16'd1});
      @(negedge clk);
      start = 0;
      @(posedge clk); #1;
      check("len1_run", outs(), {1'b1, 1'b0, 1'b1, 1'b0, 16'd1});
      @(posedge clk); #1;
      check("len1_done", outs(), {1'b0, 1'b0, 1'b1, 1'b1, 16'd0});
      @(posedge clk); #1;
      check("len1_idle", outs(), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
